sum_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `sum` adder between up to N sequential clients, such as several `mul` units. It sits between the clients' `sum_in_a`/`sum_in_b`/`sum_out` buses and a single `sum` instance. It grants exclusive, lockable ownership of the adder per request and routes operands and results accordingly. It also provides a hold-cycle counter and a sticky watchdog flag for debug.

---
 rtl/sum_arbiter.sv | 117 +++++++++++
 tb/tb_sum_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin, lockable sharing of one combinational adder
// between N sequential clients, with a hold-cycle counter and sticky watchdog.
module sum_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_HOLD = 255,
    parameter int unsigned IDX_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   cl_a,
    input  logic [N*WIDTH-1:0]   cl_b,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     cl_result,
    output logic [WIDTH-1:0]     sum_in_a,
    output logic [WIDTH-1:0]     sum_in_b,
    input  logic [WIDTH-1:0]     sum_out,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic [15:0]          hold_cnt,
    output logic                 err
);

    localparam int unsigned     CNT_W      = 16;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    logic [IDX_W-1:0] last;
    logic             owner_req;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W:0]   rot_amt;
    logic             found;
    int unsigned      pos;
    logic [IDX_W-1:0] pick;

    logic [N-1:0]     gnt_nxt;
    logic [CNT_W-1:0] hold_nxt;
    logic             busy_nxt;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] last_nxt;
    logic             err_nxt;

    // Round-robin pick: rotate requests so the client after `last` sits at bit 0.
    always_comb begin
        req_dbl = {req, req};
        rot_amt = (IDX_W+1)'(last) + (IDX_W+1)'(1);
        req_rot = N'(req_dbl >> rot_amt);
        found   = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        pick = IDX_W'((32'(last) + 32'd1 + pos) % N);
    end

    assign owner_req = |(gnt & req);

    // Next grant state: hold the lock while the owner requests, else re-arbitrate.
    always_comb begin
        gnt_nxt   = gnt;
        hold_nxt  = hold_cnt;
        owner_nxt = owner;
        last_nxt  = last;
        if (owner_req) begin
            hold_nxt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
        end else if (found) begin
            gnt_nxt   = N'(1) << pick;
            owner_nxt = pick;
            last_nxt  = pick;
            hold_nxt  = CNT_W'(1);
        end else begin
            gnt_nxt  = '0;
            hold_nxt = '0;
        end
        busy_nxt = |gnt_nxt;
        err_nxt  = err | (busy_nxt && (hold_nxt >= HOLD_LIMIT));
    end

    // State registers; reset leaves client 0 with top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            last     <= IDX_W'(N - 1);
            hold_cnt <= '0;
            err      <= 1'b0;
        end else begin
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            err      <= err_nxt;
        end
    end

    // Operand mux: one-hot OR of the granted client's operands, zero when idle.
    always_comb begin
        sum_in_a = '0;
        sum_in_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sum_in_a = sum_in_a | cl_a[i*WIDTH +: WIDTH];
                sum_in_b = sum_in_b | cl_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign cl_result = sum_out;

endmodule

// File: tb/tb_sum_arbiter.sv
// tb_sum_arbiter: vector table, hand sequences and random run against a reference model.
module tb_sum_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXH = 8;
    localparam int IW   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] cl_a;
    logic [N*W-1:0] cl_b;
    logic [N-1:0]   gnt;
    logic [W-1:0]   cl_result;
    logic [W-1:0]   sum_in_a;
    logic [W-1:0]   sum_in_b;
    logic [W-1:0]   sum_out;
    logic           busy;
    logic [IW-1:0]  owner;
    logic [15:0]    hold_cnt;
    logic           err;

    always #5 clk = ~clk;

    // Behavioural shared adder.
    assign sum_out = sum_in_a + sum_in_b;

    sum_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(MAXH), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .cl_a(cl_a), .cl_b(cl_b),
        .gnt(gnt), .cl_result(cl_result), .sum_in_a(sum_in_a), .sum_in_b(sum_in_b),
        .sum_out(sum_out), .busy(busy), .owner(owner), .hold_cnt(hold_cnt), .err(err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [IW-1:0] owner;
        logic [15:0]   hold;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g,
                                input logic [IW-1:0] o, input logic [15:0] h);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.owner = o; v.hold = h;
        vq.push_back(v);
    endfunction

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model state.
    int m_own, m_last, m_oreg, m_hold;
    bit m_err;

    function automatic void model_step(input logic r, input logic [N-1:0] rq);
        if (r) begin
            m_own = -1; m_last = N - 1; m_oreg = 0; m_hold = 0; m_err = 0;
        end else if (m_own >= 0 && rq[m_own]) begin
            m_hold = (m_hold >= 65535) ? 65535 : m_hold + 1;
            if (m_hold >= MAXH) m_err = 1;
        end else begin
            int f;
            f = -1;
            for (int k = 1; k <= N; k++) begin
                if (f < 0 && rq[(m_last + k) % N]) f = (m_last + k) % N;
            end
            if (f >= 0) begin
                m_own = f; m_last = f; m_oreg = f; m_hold = 1;
                if (m_hold >= MAXH) m_err = 1;
            end else begin
                m_own = -1; m_hold = 0;
            end
        end
    endfunction

    initial begin
        logic [N-1:0]  eg;
        logic [W-1:0]  ea;
        logic [W-1:0]  eb;
        int            acc [2];
        int            rem [2];
        int            xv  [2];
        int            order[$];
        int            ncyc;
        logic          r_rst;

        rst  = 1'b1;
        req  = '0;
        for (int i = 0; i < N; i++) begin
            cl_a[i*W +: W] = W'(i + 1);
            cl_b[i*W +: W] = W'(i);
        end

        // Reset, single client, simultaneous requests, fairness, lock.
        add(1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0100, 4'b0100, 2, 1);
        add(0, 4'b0100, 4'b0100, 2, 2);
        add(0, 4'b0100, 4'b0100, 2, 3);
        add(0, 4'b0000, 4'b0000, 2, 0);
        add(1, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b0001, 0, 2);
        add(0, 4'b1110, 4'b0010, 1, 1);
        add(0, 4'b1110, 4'b0010, 1, 2);
        add(0, 4'b1100, 4'b0100, 2, 1);
        add(0, 4'b1100, 4'b0100, 2, 2);
        add(0, 4'b1000, 4'b1000, 3, 1);
        add(0, 4'b1000, 4'b1000, 3, 2);
        add(0, 4'b0000, 4'b0000, 3, 0);
        add(0, 4'b0010, 4'b0010, 1, 1);
        add(0, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b1001, 4'b1000, 3, 1);
        add(0, 4'b0001, 4'b0001, 0, 1);
        add(0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 4'b0001, 0, 1);
        add(0, 4'b0011, 4'b0001, 0, 2);
        add(0, 4'b0011, 4'b0001, 0, 3);
        add(0, 4'b0010, 4'b0010, 1, 1);
        add(0, 4'b0000, 4'b0000, 1, 0);
        // Owner re-request after one low cycle loses priority to a waiter.
        add(0, 4'b0101, 4'b0100, 2, 1);
        add(0, 4'b0001, 4'b0001, 0, 1);
        add(0, 4'b0101, 4'b0001, 0, 2);
        add(0, 4'b0100, 4'b0100, 2, 1);
        add(0, 4'b0000, 4'b0000, 2, 0);

        foreach (vq[n]) begin
            rst = vq[n].rst;
            req = vq[n].req;
            cyc();
            ea = '0; eb = '0;
            for (int i = 0; i < N; i++) if (vq[n].gnt[i]) begin ea = W'(i + 1); eb = W'(i); end
            chk("tbl_gnt",   32'(gnt),       32'(vq[n].gnt));
            chk("tbl_busy",  32'(busy),      32'(|vq[n].gnt));
            chk("tbl_owner", 32'(owner),     32'(vq[n].owner));
            chk("tbl_hold",  32'(hold_cnt),  32'(vq[n].hold));
            chk("tbl_err",   32'(err),       32'd0);
            chk("tbl_sa",    32'(sum_in_a),  32'(ea));
            chk("tbl_sb",    32'(sum_in_b),  32'(eb));
            chk("tbl_res",   32'(cl_result), 32'(ea + eb));
        end

        // Watchdog: client 0 holds for 12 cycles.
        rst = 1'b1; req = '0; cyc(); rst = 1'b0;
        req = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("wd_gnt",  32'(gnt),      32'd1);
            chk("wd_hold", 32'(hold_cnt), 32'(k));
            chk("wd_err",  32'(err),      32'(k >= MAXH));
        end
        req = '0;
        cyc();
        chk("wd_rel_gnt", 32'(gnt), 32'd0);
        chk("wd_sticky",  32'(err), 32'd1);
        cyc();
        chk("wd_sticky2", 32'(err), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("wd_rst_err", 32'(err), 32'd0);

        // Two multiply-by-repeated-add clients sharing the adder.
        xv[0] = 4;   rem[0] = 3;   acc[0] = 0;
        xv[1] = 255; rem[1] = 255; acc[1] = 0;
        for (int i = 0; i < 2; i++) begin
            cl_a[i*W +: W] = W'(acc[i]);
            cl_b[i*W +: W] = W'(xv[i]);
        end
        req  = 4'b0011;
        ncyc = 0;
        while ((rem[0] > 0 || rem[1] > 0) && ncyc < 1000) begin
            cyc();
            ncyc++;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i] && rem[i] > 0) begin
                    if (order.size() == 0 || order[order.size()-1] != i) order.push_back(i);
                    acc[i] = int'(cl_result);
                    rem[i]--;
                    cl_a[i*W +: W] = W'(acc[i]);
                    if (rem[i] == 0) req[i] = 1'b0;
                end
            end
        end
        chk("mul_cycles", 32'(ncyc),  32'd258);
        chk("mul_p0",     32'(acc[0]), 32'd12);
        chk("mul_p1",     32'(acc[1]), 32'd65025);
        chk("mul_order_n", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("mul_order0", 32'(order[0]), 32'd0);
            chk("mul_order1", 32'(order[1]), 32'd1);
        end
        cyc();
        chk("mul_idle", 32'(gnt), 32'd0);
        chk("mul_err",  32'(err), 32'd1);
        req = 4'b0010;
        cyc(); cyc(); cyc();
        chk("mid_gnt", 32'(gnt), 32'b0010);
        rst = 1'b1;
        cyc();
        chk("mid_rst_gnt",   32'(gnt),      32'd0);
        chk("mid_rst_err",   32'(err),      32'd0);
        chk("mid_rst_owner", 32'(owner),    32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_hold",  32'(hold_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_gnt",   32'(gnt),   32'b0010);
        chk("post_rst_owner", 32'(owner), 32'd1);
        req = '0;

        // Randomized run against the reference model.
        rst = 1'b1; cyc(); model_step(1'b1, '0);
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            cl_a = {$urandom, $urandom};
            cl_b = {$urandom, $urandom};
            rst  = r_rst;
            model_step(r_rst, req);
            cyc();
            eg = (m_own >= 0) ? N'(1) << m_own : '0;
            ea = (m_own >= 0) ? cl_a[m_own*W +: W] : '0;
            eb = (m_own >= 0) ? cl_b[m_own*W +: W] : '0;
            chk("rnd_gnt",   32'(gnt),       32'(eg));
            chk("rnd_busy",  32'(busy),      32'(m_own >= 0));
            chk("rnd_owner", 32'(owner),     32'(m_oreg));
            chk("rnd_hold",  32'(hold_cnt),  32'(m_hold));
            chk("rnd_err",   32'(err),       32'(m_err));
            chk("rnd_sa",    32'(sum_in_a),  32'(ea));
            chk("rnd_sb",    32'(sum_in_b),  32'(eb));
            chk("rnd_res",   32'(cl_result), 32'(W'(ea + eb)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
